uart_rx_sim: RTL and testbench
==============================

UART_RX_SIM -- requirements
Module: uart_rx_sim

Interface
REQ-001 SHALL have parameter PACE_BITS, default 7, width of the free-running delivery pace counter.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, number of injected bytes buffered; power of two.
REQ-003 SHALL have port clk  input  1  clock, all logic on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port inject_valid  input  1  bench offers one byte this cycle.
REQ-006 SHALL have port inject_data  input  8  byte offered by bench.
REQ-007 SHALL have port inject_ready  output  1  FIFO not full, byte accepted when inject_valid & inject_ready.
REQ-008 SHALL have port rd_req  input  1  CPU register read strobe, one cycle.
REQ-009 SHALL have port rd_addr  input  1  0 = status register, 1 = data register.
REQ-010 SHALL have port rd_ok  output  1  read response valid.
REQ-011 SHALL have port rd_data  output  32  read response.

Function
REQ-012 SHALL free-run pace counter, +1 per cycle, wrap at 2^PACE_BITS; tick = counter all ones.
REQ-013 SHALL on tick with FIFO non-empty and rx_full = 0, pop one byte into holding register and set rx_full the next cycle.
REQ-014 SHALL on tick with rx_full = 1, leave FIFO untouched (stall, no byte loss).
REQ-015 SHALL assert rd_ok exactly one cycle after each rd_req, deasserted otherwise; rd_data = 0 when rd_ok = 0.
REQ-016 SHALL return status as {28'b0, fifo_full, drop, fifo_nonempty, rx_full}, sampled in the rd_req cycle.
REQ-017 SHALL return data as {24'b0, holding byte} and clear rx_full in the cycle after rd_req.
REQ-018 SHALL on data read with rx_full = 0 return the last holding byte and leave rx_full at 0.
REQ-019 SHALL on tick coinciding with a data-read rd_req, complete the read and defer delivery to the next tick.
REQ-020 SHALL on inject_valid with FIFO full, drop the byte and set sticky drop flag.
REQ-021 SHALL clear drop in the cycle after a status read; a drop in that same cycle keeps drop set.
REQ-022 SHALL accept a push and a pop in the same cycle on a full FIFO only if inject_ready was 1 (push ignored when full, regardless of pop).

Reset
REQ-023 SHALL on reset clear pace counter, FIFO pointers/count, holding register, rx_full, drop, rd_ok, rd_data.
REQ-024 SHALL drive inject_ready = 1 from the first cycle after reset.
REQ-025 SHALL discard a rd_req issued in a reset cycle (no rd_ok follows).

Configuration
REQ-026 SHALL with UART_RX_ECHO_EN defined, $write each byte as %c at the moment it enters the holding register.
REQ-027 SHALL without UART_RX_ECHO_EN, produce no console output; functional behaviour identical.

Structure
REQ-028 SHALL place status bit positions, register address constants and default widths in package uart_rx_sim_pkg.
REQ-029 SHALL implement buffering in sub-module uart_rx_fifo (push, pop, data_out, empty, full, count).

Verification
REQ-030 SHALL test: reset, inject 0x41 at cycle 5, poll status -> rx_full = 1 after first tick (cycle 127+1), data read returns 0x00000041, next status rx_full = 0.
REQ-031 SHALL test: inject 0x31,0x32,0x33 back-to-back, read data after each tick -> 0x31,0x32,0x33 in order, one per 128 cycles.
REQ-032 SHALL test: inject 17 bytes with no reads -> 17th dropped while FIFO full, inject_ready = 0, status = 0x0000000F after first delivery, next status drop = 0.
REQ-033 SHALL test: no data read across two ticks with 2 bytes queued -> holding keeps first byte, fifo_nonempty stays 1, no loss.
REQ-034 SHALL test: data rd_req on the tick cycle -> rd_ok next cycle with old byte, new byte delivered at following tick.
REQ-035 SHALL test: reset asserted mid-operation with 3 bytes queued and rx_full = 1 -> status reads 0x00000000 afterwards.

Source files
------------

// File: rtl/uart_rx_sim_pkg.sv
// Shared constants for the simulated UART receiver: default widths,
// register addresses and status bit positions.
package uart_rx_sim_pkg;

    localparam int PACE_BITS_DEF  = 7;
    localparam int FIFO_DEPTH_DEF = 16;

    localparam logic ADDR_STATUS = 1'b0;
    localparam logic ADDR_DATA   = 1'b1;

    localparam int STAT_RX_FULL   = 0;
    localparam int STAT_NONEMPTY  = 1;
    localparam int STAT_DROP      = 2;
    localparam int STAT_FIFO_FULL = 3;

endpackage

// File: rtl/uart_rx_fifo.sv
// Byte FIFO buffering injected characters until the receiver pace tick
// moves them into the holding register. Push is ignored while full,
// even if a pop happens in the same cycle.
module uart_rx_fifo
    import uart_rx_sim_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [7:0]    data_in,
    input  logic          pop,
    output logic [7:0]    data_out,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count
);

    localparam logic [AW-1:0] PTR_ONE    = 1;
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [AW:0]   r_count;
    logic          w_doPush;
    logic          w_doPop;

    assign full     = (r_count == FULL_COUNT);
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign data_out = r_mem[r_rdPtr];
    assign w_doPush = push & ~full;
    assign w_doPop  = pop & ~empty;

    // Storage array; contents need no reset because the count guards reads.
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= data_in;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since depth is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + PTR_ONE;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + PTR_ONE;
            end
            r_count <= r_count + {{AW{1'b0}}, w_doPush} - {{AW{1'b0}}, w_doPop};
        end
    end

endmodule

// File: rtl/uart_rx_sim.sv
// Simulated UART receiver: the bench injects bytes into a FIFO, a free-running
// pace counter delivers one byte per tick into a holding register, and a CPU
// reads status/data registers with a one-cycle response.
// Optional feature: define UART_RX_ECHO_EN to echo each delivered byte to the console.
module uart_rx_sim
    import uart_rx_sim_pkg::*;
#(
    parameter int PACE_BITS  = PACE_BITS_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inject_valid,
    input  logic [7:0]  inject_data,
    output logic        inject_ready,
    input  logic        rd_req,
    input  logic        rd_addr,
    output logic        rd_ok,
    output logic [31:0] rd_data
);

    localparam int FIFO_AW = $clog2(FIFO_DEPTH);
    localparam logic [PACE_BITS-1:0] PACE_ONE = 1;

    logic [PACE_BITS-1:0] r_pace;
    logic [7:0]           r_holding;
    logic                 r_rxFull;
    logic                 r_drop;
    logic                 r_rdOk;
    logic [31:0]          r_rdData;

    logic                 w_tick;
    logic                 w_statusRead;
    logic                 w_dataRead;
    logic                 w_pop;
    logic                 w_dropEvent;
    logic [7:0]           w_fifoData;
    logic                 w_fifoEmpty;
    logic                 w_fifoFull;
    logic [FIFO_AW:0]     w_fifoCount;
    logic [31:0]          w_rdMux;

    assign w_tick       = &r_pace;
    assign w_statusRead = rd_req & (rd_addr == ADDR_STATUS);
    assign w_dataRead   = rd_req & (rd_addr == ADDR_DATA);
    assign w_pop        = w_tick & ~w_fifoEmpty & ~r_rxFull & ~w_dataRead;
    assign w_dropEvent  = inject_valid & w_fifoFull;
    assign inject_ready = ~w_fifoFull;
    assign rd_ok        = r_rdOk;
    assign rd_data      = r_rdData;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (inject_valid),
        .data_in  (inject_data),
        .pop      (w_pop),
        .data_out (w_fifoData),
        .empty    (w_fifoEmpty),
        .full     (w_fifoFull),
        .count    (w_fifoCount)
    );

    // Free-running pace counter; the all-ones value is the delivery tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pace <= '0;
        end else begin
            r_pace <= r_pace + PACE_ONE;
        end
    end

    // Holding register: loaded on a tick pop, emptied by a data read.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_holding <= '0;
            r_rxFull  <= 1'b0;
        end else if (w_pop) begin
            r_holding <= w_fifoData;
            r_rxFull  <= 1'b1;
        end else if (w_dataRead) begin
            r_rxFull  <= 1'b0;
        end
    end

    // Sticky drop flag; a new drop wins over the clear from a status read.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop <= 1'b0;
        end else begin
            r_drop <= (r_drop & ~w_statusRead) | w_dropEvent;
        end
    end

    // Read response mux, sampled in the request cycle; zero when nothing is read.
    always_comb begin
        w_rdMux = '0;
        if (w_statusRead) begin
            w_rdMux[STAT_RX_FULL]   = r_rxFull;
            w_rdMux[STAT_NONEMPTY]  = |w_fifoCount;
            w_rdMux[STAT_DROP]      = r_drop;
            w_rdMux[STAT_FIFO_FULL] = w_fifoFull;
        end else if (w_dataRead) begin
            w_rdMux[7:0] = r_holding;
        end
    end

    // One-cycle read response register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdOk   <= 1'b0;
            r_rdData <= '0;
        end else begin
            r_rdOk   <= rd_req;
            r_rdData <= w_rdMux;
        end
    end

`ifdef UART_RX_ECHO_EN
    // Console echo of each byte as it enters the holding register.
    always_ff @(posedge clk) begin
        if (!reset && w_pop) begin
            $write("%c", w_fifoData);
        end
    end
`else
    // Silent build: no console output, identical behaviour.
`endif

endmodule

// File: tb/tb_uart_rx_sim.sv
// Directed bench for uart_rx_sim. All expected values are hand-derived:
// after reset release the bench counts cycles in cyc, the pace counter equals
// cyc mod 128, so ticks land on cycles 127, 255, 383, ...
module tb_uart_rx_sim;

    logic        clk = 1'b0;
    logic        reset;
    logic        inject_valid;
    logic [7:0]  inject_data;
    logic        inject_ready;
    logic        rd_req;
    logic        rd_addr;
    logic        rd_ok;
    logic [31:0] rd_data;

    int testsRun    = 0;
    int testsFailed = 0;
    int cyc         = 0;

    uart_rx_sim #(
        .PACE_BITS  (7),
        .FIFO_DEPTH (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .inject_valid (inject_valid),
        .inject_data  (inject_data),
        .inject_ready (inject_ready),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_ok        (rd_ok),
        .rd_data      (rd_data)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic waitUntil(input int target);
        while (cyc < target) step();
    endtask

    task automatic doReset(input logic holdReq);
        reset        = 1'b1;
        inject_valid = 1'b0;
        rd_req       = holdReq;
        rd_addr      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        rd_req = 1'b0;
        cyc    = 0;
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        inject_valid = 1'b1;
        inject_data  = b;
        step();
        inject_valid = 1'b0;
    endtask

    task automatic readReg(input string tag, input logic addr, input logic [31:0] exp);
        rd_req  = 1'b1;
        rd_addr = addr;
        step();
        rd_req  = 1'b0;
        checkOutput({tag, ".ok"}, 32'(rd_ok), 32'd1);
        checkOutput(tag, rd_data, exp);
    endtask

    initial begin
        reset        = 1'b1;
        inject_valid = 1'b0;
        inject_data  = 8'h00;
        rd_req       = 1'b0;
        rd_addr      = 1'b0;

        // Single byte: reset state, delivery at first tick, read clears rx_full.
        doReset(1'b0);
        checkOutput("rst.rd_ok", 32'(rd_ok), 32'd0);
        checkOutput("rst.rd_data", rd_data, 32'd0);
        checkOutput("rst.ready", 32'(inject_ready), 32'd1);
        step();
        readReg("rst.status", 1'b0, 32'h0);
        waitUntil(5);
        applyStimulus(8'h41);
        waitUntil(126);
        readReg("t1.pre_tick", 1'b0, 32'h2);
        waitUntil(128);
        readReg("t1.rx_full", 1'b0, 32'h1);
        readReg("t1.data", 1'b1, 32'h41);
        readReg("t1.cleared", 1'b0, 32'h0);
        readReg("t1.reread", 1'b1, 32'h41);
        step();
        checkOutput("t1.idle_ok", 32'(rd_ok), 32'd0);
        checkOutput("t1.idle_data", rd_data, 32'd0);

        // Three bytes delivered in order, one per tick.
        waitUntil(140);
        applyStimulus(8'h31);
        applyStimulus(8'h32);
        applyStimulus(8'h33);
        for (int k = 0; k < 3; k++) begin
            waitUntil(256 + 128 * k);
            readReg("t2.data", 1'b1, 32'h31 + 32'(k));
        end
        readReg("t2.empty", 1'b0, 32'h0);

        // No read across two ticks: holding keeps first byte, second waits.
        doReset(1'b0);
        waitUntil(2);
        applyStimulus(8'h51);
        applyStimulus(8'h52);
        waitUntil(300);
        readReg("t3.stall", 1'b0, 32'h3);
        readReg("t3.first", 1'b1, 32'h51);
        waitUntil(384);
        readReg("t3.second", 1'b1, 32'h52);
        readReg("t3.done", 1'b0, 32'h0);

        // Data read on the tick cycle: old byte returned, delivery deferred.
        doReset(1'b0);
        waitUntil(2);
        applyStimulus(8'h61);
        applyStimulus(8'h62);
        waitUntil(255);
        readReg("t4.tick_read", 1'b1, 32'h61);
        readReg("t4.deferred", 1'b0, 32'h2);
        waitUntil(384);
        readReg("t4.next_tick", 1'b0, 32'h1);
        readReg("t4.new_byte", 1'b1, 32'h62);
        waitUntil(390);
        applyStimulus(8'h63);
        waitUntil(511);
        readReg("t4.empty_tick", 1'b1, 32'h62);
        readReg("t4.defer_empty", 1'b0, 32'h2);
        waitUntil(640);
        readReg("t4.late_byte", 1'b1, 32'h63);

        // Overflow: 17th byte dropped; refill after first delivery gives 0xF.
        doReset(1'b0);
        waitUntil(2);
        for (int i = 0; i < 17; i++) begin
            if (i == 16) checkOutput("t5.ready_full", 32'(inject_ready), 32'd0);
            applyStimulus(8'h70 + 8'(i));
        end
        waitUntil(130);
        checkOutput("t5.ready_again", 32'(inject_ready), 32'd1);
        applyStimulus(8'h90);
        inject_valid = 1'b1;
        inject_data  = 8'h91;
        readReg("t5.status", 1'b0, 32'hF);
        inject_valid = 1'b0;
        readReg("t5.drop_kept", 1'b0, 32'hF);
        readReg("t5.drop_clr", 1'b0, 32'hB);
        readReg("t5.byte0", 1'b1, 32'h70);
        for (int k = 2; k <= 17; k++) begin
            waitUntil(128 * k);
            readReg("t5.drain", 1'b1, (k == 17) ? 32'h90 : 32'h6F + 32'(k));
        end
        readReg("t5.drained", 1'b0, 32'h0);

        // Reset mid-operation with a read request in the reset cycle.
        doReset(1'b0);
        waitUntil(2);
        for (int i = 0; i < 4; i++) applyStimulus(8'hA0 + 8'(i));
        waitUntil(200);
        readReg("t6.before", 1'b0, 32'h3);
        doReset(1'b1);
        checkOutput("t6.no_rd_ok", 32'(rd_ok), 32'd0);
        checkOutput("t6.ready", 32'(inject_ready), 32'd1);
        readReg("t6.status", 1'b0, 32'h0);
        readReg("t6.holding", 1'b1, 32'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
